mlp_neuron_acc: RTL and testbench

MLP_NEURON_ACC -- requirements
Module: mlp_neuron_acc

---
 rtl/mlp_neuron_acc.sv | 165 ++++++++++++++++
 tb/tb_mlp_neuron_acc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mlp_neuron_acc.sv
// Streaming multiply-accumulate neuron: bias + sum(i*w) with saturation and selectable activation.
// A beat's product is registered on accept and folded into the accumulator on the following edge.
module mlp_neuron_acc #(
    parameter int IN_W     = 4,
    parameter int ACC_W    = 16,
    parameter int MAX_TAPS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_i,
    input  logic [IN_W-1:0]         in_w,
    input  logic                    in_last,
    input  logic [ACC_W-1:0]        bias,
    input  logic [1:0]              act_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [ACC_W-1:0]        out_raw,
    output logic                    out_sat,
    output logic                    out_err
);
    localparam int unsigned PW = 2 * IN_W;
    localparam int unsigned CW = $clog2(MAX_TAPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_t;

    state_t                   r_state;
    logic                     r_in_ready;
    logic signed [PW-1:0]     r_prod;
    logic                     r_prod_vld;
    logic signed [ACC_W-1:0]  r_acc;
    logic [1:0]               r_mode;
    logic                     r_sat;
    logic                     r_err;
    logic [CW-1:0]            r_cnt;
    logic                     r_out_valid;
    logic [ACC_W-1:0]         r_out_data;
    logic [ACC_W-1:0]         r_out_raw;
    logic                     r_out_sat;
    logic                     r_out_err;

    logic signed [PW-1:0]     w_i_ext;
    logic signed [PW-1:0]     w_w_ext;
    logic signed [PW-1:0]     w_mult;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W:0]    w_sum;
    logic                     w_clamp;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_act;
    logic                     w_accept;
    logic [CW-1:0]            w_next_cnt;
    logic                     w_full;
    logic                     w_last;

    // Product, saturating add and activation datapath
    always_comb begin
        w_i_ext    = {{IN_W{in_i[IN_W-1]}}, in_i};
        w_w_ext    = {{IN_W{in_w[IN_W-1]}}, in_w};
        w_mult     = w_i_ext * w_w_ext;
        w_prod_ext = {{(ACC_W-PW){r_prod[PW-1]}}, r_prod};
        w_sum      = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
        w_clamp    = w_sum[ACC_W] != w_sum[ACC_W-1];
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_clamp) begin
            w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        case (r_mode)
            2'b00:   w_act = r_acc;
            2'b10:   w_act = r_acc[ACC_W-1] ? (r_acc >>> 3) : r_acc;
            default: w_act = (r_acc > ACC_W'(signed'(0))) ? r_acc : ACC_W'(signed'(0));
        endcase
    end

    // Beat bookkeeping; reaching MAX_TAPS forces the vector to close
    always_comb begin
        w_accept   = in_valid && r_in_ready;
        w_next_cnt = (r_state == S_IDLE) ? CW'(1) : r_cnt + CW'(1);
        w_full     = w_next_cnt == CW'(MAX_TAPS);
        w_last     = in_last || w_full;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_acc       <= '0;
            r_mode      <= 2'b00;
            r_sat       <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_raw   <= '0;
            r_out_sat   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_prod_vld <= w_accept;
            if (w_accept) begin
                r_prod <= w_mult;
            end
            if (r_prod_vld) begin
                r_acc <= w_acc_next;
                if (w_clamp) begin
                    r_sat <= 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc  <= bias;
                        r_mode <= act_mode;
                        r_sat  <= 1'b0;
                        r_err  <= !in_last && w_full;
                        r_cnt  <= w_next_cnt;
                        if (w_last) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_cnt <= w_next_cnt;
                        if (w_last) begin
                            r_err      <= !in_last && w_full;
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Wait until the last product has been folded in
                    if (!r_prod_vld) begin
                        r_out_data  <= w_act;
                        r_out_raw   <= r_acc;
                        r_out_sat   <= r_sat;
                        r_out_err   <= r_err;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_raw   = r_out_raw;
    assign out_sat   = r_out_sat;
    assign out_err   = r_out_err;
endmodule

// File: tb/tb_mlp_neuron_acc.sv
// Scoreboard bench for mlp_neuron_acc: driver pushes hand-computed results, a monitor pops on handshake.
module tb_mlp_neuron_acc;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [3:0]  in_i;
    logic signed [3:0]  in_w;
    logic               in_last;
    logic signed [15:0] bias;
    logic [1:0]         act_mode;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic signed [15:0] out_raw;
    logic               out_sat;
    logic               out_err;

    typedef struct {
        int data;
        int raw;
        int sat;
        int err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mlp_neuron_acc #(.IN_W(4), .ACC_W(16), .MAX_TAPS(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_i(in_i), .in_w(in_w), .in_last(in_last), .bias(bias), .act_mode(act_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_raw(out_raw), .out_sat(out_sat), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every handshaken result against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", int'(out_data), e.data);
                chk("out_raw", int'(out_raw), e.raw);
                chk("out_sat", int'(out_sat), e.sat);
                chk("out_err", int'(out_err), e.err);
            end
        end
    end

    task automatic push(input int data, input int raw, input int sat, input int err);
        exp_t e;
        e.data = data; e.raw = raw; e.sat = sat; e.err = err;
        q.push_back(e);
    endtask

    // Present one beat from a falling edge and hold it until accepted
    task automatic beat(input logic signed [3:0] i, input logic signed [3:0] w, input logic last);
        bit ok;
        @(negedge clk);
        in_i = i; in_w = w; in_last = last; in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Called right after the last accept: out_valid must rise on the second edge
    task automatic latency(input string nm);
        @(negedge clk); chk({nm, "_valid_e0"}, int'(out_valid), 0);
        @(negedge clk); chk({nm, "_valid_e1"}, int'(out_valid), 0);
        @(negedge clk); chk({nm, "_valid_e2"}, int'(out_valid), 1);
    endtask

    task automatic one(input string nm, input int b, input logic [1:0] m,
                       input logic signed [3:0] i, input logic signed [3:0] w,
                       input int data, input int raw, input int sat);
        bias = 16'(b); act_mode = m;
        push(data, raw, sat, 0);
        beat(i, w, 1'b1);
        latency(nm);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_i = '0; in_w = '0; in_last = 1'b0;
        bias = '0; act_mode = 2'b00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_raw", int'(out_raw), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Two-beat ReLU vector with consumer stalled for 5 cycles
        @(posedge clk); #1 out_ready = 1'b0;
        bias = 16'sd0; act_mode = 2'b01;
        push(2, 2, 0, 0);
        beat(4'sd3, 4'sd2, 1'b0);
        beat(-4'sd1, 4'sd4, 1'b1);
        latency("relu2");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_out_data", int'(out_data), 2);
            chk("stall_out_raw", int'(out_raw), 2);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);

        // Activation modes on a negative sum
        one("ident_neg", -10, 2'b00, 4'sd1, 4'sd1, -9, -9, 0);
        one("relu_neg", -10, 2'b01, 4'sd1, 4'sd1, 0, -9, 0);
        one("leaky_neg", -10, 2'b10, 4'sd1, 4'sd1, -2, -9, 0);
        one("mode11_pos", 100, 2'b11, -4'sd8, -4'sd8, 164, 164, 0);

        // Saturation at both rails
        one("sat_hi", 32760, 2'b00, 4'sd7, 4'sd7, 32767, 32767, 1);
        one("sat_lo", -32768, 2'b00, -4'sd8, 4'sd7, -32768, -32768, 1);

        // Multi-beat leaky: 64 - 56 - 15 = -7, -7 >>> 3 = -1
        bias = 16'sd0; act_mode = 2'b10;
        push(-1, -7, 0, 0);
        beat(-4'sd8, -4'sd8, 1'b0);
        beat(4'sd7, -4'sd8, 1'b0);
        beat(4'sd3, -4'sd5, 1'b1);
        latency("leaky3");

        // Truncation at MAX_TAPS, then a held-off beat forms its own vector
        bias = 16'sd0; act_mode = 2'b00;
        push(16, 16, 0, 1);
        for (int k = 0; k < 16; k++) beat(4'sd1, 4'sd1, 1'b0);
        in_i = 4'sd2; in_w = 4'sd3; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("trunc_in_ready_low", int'(in_ready), 0);
        end
        chk("trunc_out_valid", int'(out_valid), 1);
        push(6, 6, 0, 0);
        beat(4'sd2, 4'sd3, 1'b1);
        latency("after_trunc");

        // Reset mid-vector discards the partial result
        bias = 16'sd100; act_mode = 2'b00;
        beat(4'sd1, 4'sd1, 1'b0);
        beat(4'sd1, 4'sd1, 1'b0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_valid", int'(out_valid), 0);
        end
        one("after_rst", 5, 2'b00, 4'sd2, 4'sd2, 9, 9, 0);

        for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
